// File: rtl/seq_mem_d1_clr_if.sv
// Access bus for the single-port Calyx sequential memory.
// Latency: n/a (wires only); done/read_data arrive one cycle after an accepted access.
// Backpressure: ready low means content_en is ignored; there is no stall beyond that.
interface seq_mem_d1_clr_if #(
   parameter int WIDTH    = 32,
   parameter int IDX_SIZE = 4
);
   logic [IDX_SIZE-1:0] addr0;
   logic                content_en;
   logic                write_en;
   logic [WIDTH-1:0]    write_data;
   logic [WIDTH-1:0]    read_data;
   logic                done;
   logic                ready;
   logic                oob_err;

   // Requester side: issues accesses, observes results.
   modport master (
      output addr0, content_en, write_en, write_data,
      input  read_data, done, ready, oob_err
   );

   // Memory side: accepts accesses, returns results.
   modport slave (
      input  addr0, content_en, write_en, write_data,
      output read_data, done, ready, oob_err
   );
endinterface

// File: rtl/seq_mem_d1_clr.sv
// Single-port 1-D memory with registered read, done pulse, optional zero-fill after reset.
// Latency: 1 cycle from accepted access to done (read_data valid with done).
// Backpressure: accesses are dropped (no done) while ready is low during the zero-fill.
module seq_mem_d1_clr #(
   parameter int WIDTH      = 32,
   parameter int SIZE       = 16,
   parameter int IDX_SIZE   = 4,
   parameter int INIT_CLEAR = 1,
   parameter int OOB_MSG    = 1
) (
   input logic              clk,
   input logic              reset,
   seq_mem_d1_clr_if.slave  bus
);

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_IDLE  = 1'b1
   } state_t;

   localparam logic [IDX_SIZE-1:0] LAST_IDX = IDX_SIZE'(SIZE - 1);

   state_t              state;
   state_t              state_nxt;
   logic [IDX_SIZE-1:0] clr_idx;
   logic [IDX_SIZE-1:0] clr_idx_nxt;
   logic                clr_we;

   logic [WIDTH-1:0]    mem [SIZE];

   logic [WIDTH-1:0]    read_data_q;
   logic                done_q;
   logic                ready_q;
   logic                oob_err_q;

   logic                acc;
   logic                in_bnd;

   // The bounds check uses the full address width so SIZE < 2**IDX_SIZE leaves real holes.
   assign in_bnd = (32'(bus.addr0) < 32'(SIZE));
   // Gating with reset keeps a held-in-reset IDLE memory (INIT_CLEAR=0) from writing.
   assign acc    = (state == S_IDLE) && bus.content_en && !reset;

   // State and fill-pointer registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= (INIT_CLEAR != 0) ? S_CLEAR : S_IDLE;
         clr_idx <= '0;
      end else begin
         state   <= state_nxt;
         clr_idx <= clr_idx_nxt;
      end
   end

   // Next-state: walk clr_idx through every word, then settle in IDLE until reset.
   always_comb begin
      state_nxt   = state;
      clr_idx_nxt = clr_idx;
      clr_we      = 1'b0;
      case (state)
         S_CLEAR: begin
            clr_we = !reset;
            if (clr_idx == LAST_IDX) begin
               state_nxt   = S_IDLE;
               clr_idx_nxt = '0;
            end else begin
               clr_idx_nxt = clr_idx + 1'b1;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Storage array: zero-fill has priority; user writes only land in bounds.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_idx] <= '0;
      end else if (acc && bus.write_en && in_bnd) begin
         mem[bus.addr0] <= bus.write_data;
      end
   end

   // Result registers: read data, done pulse, ready flag and sticky out-of-bounds error.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         read_data_q <= '0;
         done_q      <= 1'b0;
         ready_q     <= 1'b0;
         oob_err_q   <= 1'b0;
      end else begin
         done_q  <= acc;
         ready_q <= (state_nxt == S_IDLE);
         if (acc && !bus.write_en) begin
            read_data_q <= in_bnd ? mem[bus.addr0] : '0;
         end
         if (acc && !in_bnd) begin
            oob_err_q <= 1'b1;
         end
      end
   end

   // Flag an accepted out-of-range access during simulation.
   always @(posedge clk) begin
      if ((OOB_MSG != 0) && acc && !in_bnd) begin
         $error("seq_mem_d1_clr: out-of-bounds access addr0=%0d SIZE=%0d", bus.addr0, SIZE);
      end
   end

   assign bus.read_data = read_data_q;
   assign bus.done      = done_q;
   assign bus.ready     = ready_q;
   assign bus.oob_err   = oob_err_q;

endmodule
